// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Brief    : Shared constants, entry type and header decode for the router
//             destination FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int DWIDTH          = 8;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 30;

    // One buffered byte plus its header tag.
    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } fifo_entry_t;

    // Header byte layout: [7:2] payload length, [1:0] destination address.
    function automatic logic [5:0] payload_len(input logic [7:0] hdr_byte);
        return hdr_byte[7:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_dst_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : router_dst_timeout
//  Brief    : Counts consecutive cycles where data is waiting (vld_out=1) but
//             the destination does not read (rd_en=0). Raises soft_reset for
//             one cycle on the TIMEOUT-th such cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module router_dst_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld_out,
    input  logic rd_en,
    output logic soft_reset
);

    localparam logic [4:0] c_TMO_LAST = 5'(TIMEOUT - 1);

    logic       w_stall;
    logic [4:0] tmo_q;
    logic [4:0] tmo_d;

    assign w_stall = vld_out && !rd_en;

    // Pulse fires in the cycle the stall count reaches its limit, so the
    // owning FIFO flushes at the following edge.
    always_comb begin
        soft_reset = 1'b0;
        tmo_d      = tmo_q;
        if (!w_stall) begin
            tmo_d = '0;
        end else if (tmo_q == c_TMO_LAST) begin
            soft_reset = 1'b1;
            tmo_d      = '0;
        end else begin
            tmo_d = tmo_q + 5'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end

endmodule
`default_nettype wire

// File: rtl/router_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : router_dst_fifo
//  Brief    : Per-destination output buffer of the 1x3 router. Stores header
//             tagged bytes, returns registered read data, tracks packet length
//             and flushes itself when the destination stalls too long.
//  Options  : ROUTER_DST_FIFO_OCCUPANCY_EN adds occupancy and pkt_done ports.
//  Revision : 1.0 - initial release
// ============================================================================
module router_dst_fifo #(
    parameter int DEPTH   = router_pkg::DEFAULT_DEPTH,
    parameter int DWIDTH  = router_pkg::DWIDTH,
    parameter int TIMEOUT = router_pkg::DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [DWIDTH-1:0] din,
    input  logic              lfd_state,
    output logic              full,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              vld_out,
    output logic              soft_reset
`ifdef ROUTER_DST_FIFO_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   pkt_done
`endif
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DWIDTH:0]   mem_q [DEPTH];
    logic [c_AW:0]     wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]     rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic [5:0]        pkt_cnt_q, pkt_cnt_d;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DWIDTH:0]   w_rd_word;
    logic              w_rd_hdr;
    logic [DWIDTH-1:0] w_rd_data;

    // Pointer MSBs differ only when the write side has lapped the read side.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign vld_out = !w_empty;
    assign dout    = dout_q;

    // A write in the pulse cycle is discarded; a pop cannot coincide with the
    // pulse because the pulse requires rd_en=0.
    assign w_push = we && !full && !soft_reset;
    assign w_pop  = rd_en && !w_empty;

    assign w_rd_word = mem_q[rd_ptr_q[c_AW-1:0]];
    assign w_rd_hdr  = w_rd_word[DWIDTH];
    assign w_rd_data = w_rd_word[DWIDTH-1:0];

    router_dst_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .rd_en      (rd_en),
        .soft_reset (soft_reset)
    );

    // Tagged byte storage; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[c_AW-1:0]] <= {lfd_state, din};
    end

    // Pointer, read-data and packet-length next state, with flush priority.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dout_d    = dout_q;
        pkt_cnt_d = pkt_cnt_q;
        if (soft_reset) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pkt_cnt_d = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = w_rd_data;
                if (w_rd_hdr)
                    pkt_cnt_d = router_pkg::payload_len(w_rd_data[7:0]) + 6'd1;
                else if (pkt_cnt_q != '0)
                    pkt_cnt_d = pkt_cnt_q - 6'd1;
            end
        end
    end

    // Control and read-data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_q    <= dout_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef ROUTER_DST_FIFO_OCCUPANCY_EN
    logic pkt_done_q, pkt_done_d;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign pkt_done  = pkt_done_q;

    // Pulse aligned with the dout of the last byte of a packet.
    always_comb begin
        pkt_done_d = !soft_reset && w_pop && !w_rd_hdr && (pkt_cnt_q == 6'd1);
    end

    // Packet-done pulse register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pkt_done_q <= 1'b0;
        else         pkt_done_q <= pkt_done_d;
    end
`endif

endmodule
`default_nettype wire
